// File: rtl/alu_uart_pkg.sv
// Shared ALU/UART definitions: ASCII codes, tx FSM states, baud helper.
// RESULT_TX_PARITY_EN adds the even-parity state to the tx FSM.
package alu_uart_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_E    = 8'h45;
  localparam logic [7:0] ASCII_R    = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_LOAD,
    ST_START,
    ST_DATA,
`ifdef RESULT_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_FIN
  } tx_state_e;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

  // Significant decimal digits, the ones digit always counts.
  function automatic logic [1:0] num_digits(
    input logic [11:0] bcd
  );
    if (bcd[11:8] != 4'd0) return 2'd3;
    if (bcd[7:4] != 4'd0)  return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic [2:0] msg_len(
    input logic        err,
    input logic [11:0] bcd
  );
    if (err) return 3'd5;
    return {1'b0, num_digits(bcd)} + 3'd2;
  endfunction

  function automatic logic [7:0] msg_byte(
    input logic        err,
    input logic [11:0] bcd,
    input logic [2:0]  idx
  );
    logic [2:0] nd;
    logic [2:0] pos;
    logic [3:0] dig;
    nd  = {1'b0, num_digits(bcd)};
    pos = idx + (3'd3 - nd);
    dig = 4'd0;
    if (err) begin
      unique case (idx)
        3'd0:    return ASCII_E;
        3'd1:    return ASCII_R;
        3'd2:    return ASCII_R;
        3'd3:    return ASCII_CR;
        default: return ASCII_LF;
      endcase
    end
    if (idx < nd) begin
      unique case (pos)
        3'd0:    dig = bcd[11:8];
        3'd1:    dig = bcd[7:4];
        default: dig = bcd[3:0];
      endcase
      return ASCII_ZERO | {4'd0, dig};
    end
    if (idx == nd) return ASCII_CR;
    return ASCII_LF;
  endfunction

endpackage

// File: rtl/bin2bcd_8bit.sv
// Sequential double-dabble: 8-bit binary to 3-digit BCD.
// Fixed 8-cycle latency after start_i, done_o pulses for one cycle.
module bin2bcd_8bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  bin_i,
  output logic        done_o,
  output logic [11:0] bcd_o
);

  logic [19:0] sh_q, sh_d, adj;
  logic [2:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        done_q, done_d;

  // One shift-and-add-3 iteration plus handshake control.
  always_comb begin
    adj    = sh_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (adj[8+4*i +: 4] >= 4'd5)
        adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
    end
    if (start_i) begin
      sh_d  = {12'd0, bin_i};
      cnt_d = 3'd0;
      run_d = 1'b1;
    end else if (run_q) begin
      sh_d  = {adj[18:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Converter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = sh_q[19:8];

endmodule

// File: rtl/result_uart_tx.sv
// Sends the ALU result as decimal ASCII + CR LF (or "ERR") over UART.
// RESULT_TX_PARITY_EN switches the frame from 8N1 to 8E1.
module result_uart_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] result,
  input  logic       div0,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  import alu_uart_pkg::*;

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BW  = $clog2(CPB);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

  tx_state_e      state_q, state_d;
  logic           err_q, err_d;
  logic [2:0]     idx_q, idx_d;
  logic [2:0]     bit_q, bit_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [7:0]     byte_q, byte_d;
  logic           tx_q, tx_d;
  logic           conv_go;
  logic           bcd_done;
  logic [11:0]    bcd_val;
  logic           baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  bin2bcd_8bit u_bcd (
    .clk     (clk),
    .rst_n   (rst),
    .start_i (conv_go),
    .bin_i   (result),
    .done_o  (bcd_done),
    .bcd_o   (bcd_val)
  );

  // Next-state: conversion, character sequencing and bit timing.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    byte_d  = byte_q;
    conv_go = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CONV;
          err_d   = div0;
          idx_d   = 3'd0;
          conv_go = ~div0;
        end
      end
      ST_CONV: begin
        if (err_q || bcd_done) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        byte_d  = msg_byte(err_q, bcd_val, idx_q);
        baud_d  = '0;
        state_d = ST_START;
      end
      ST_START: begin
        baud_d = baud_q + BW'(1);
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        baud_d = baud_q + BW'(1);
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef RESULT_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef RESULT_TX_PARITY_EN
      ST_PARITY: begin
        baud_d = baud_q + BW'(1);
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        baud_d = baud_q + BW'(1);
        if (baud_end) begin
          baud_d = '0;
          if (idx_q == msg_len(err_q, bcd_val) - 3'd1) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, registered so tx never glitches.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = byte_d[bit_d];
`ifdef RESULT_TX_PARITY_EN
      ST_PARITY: tx_d = ^byte_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      idx_q   <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign done = (state_q == ST_FIN);
  assign busy = (state_q != ST_IDLE) && (state_q != ST_FIN);

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: UART monitor feeding a byte scoreboard.
// Build with RESULT_TX_PARITY_EN to exercise the 8E1 frame.
module tb_result_uart_tx;

  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int CPB      = 16;
`ifdef RESULT_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] result = 8'd0;
  logic       div0 = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, tx;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ndone_exp = 0;
  int base, acc, nexp;
  logic [7:0] exp_q[$];
  int fall_cyc[$];

  result_uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .result (result),
    .div0   (div0),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n, inout logic ab);
    repeat (n) begin
      @(negedge clk);
      if (!rst) ab = 1'b1;
    end
  endtask

  task automatic uart_mon();
    logic [7:0] b;
    logic ab;
`ifdef RESULT_TX_PARITY_EN
    logic p;
`endif
    forever begin
      @(negedge clk);
      if (rst && tx === 1'b0) begin
        fall_cyc.push_back(cyc);
        ab = 1'b0;
        b  = 8'd0;
        hold(CPB / 2, ab);
        if (!ab) chk("start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          hold(CPB, ab);
          b[i] = tx;
        end
`ifdef RESULT_TX_PARITY_EN
        hold(CPB, ab);
        p = tx;
        if (!ab) chk("parity", 32'(p), 32'(^b));
`endif
        hold(CPB, ab);
        if (!ab) begin
          chk("stop_bit", 32'(tx), 32'd1);
          if (exp_q.size() == 0)
            chk("rx_extra", 32'(b), 32'h100);
          else
            chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
        end
      end
    end
  endtask

  task automatic done_mon();
    forever begin
      @(negedge clk);
      if (rst && done === 1'b1) done_cnt++;
    end
  endtask

  task automatic send(input logic [7:0] r, input logic d);
    string s;
    @(negedge clk);
    result = r;
    div0   = d;
    start  = 1'b1;
    s = d ? "ERR" : $sformatf("%0d", r);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    nexp = s.len() + 2;
    base = fall_cyc.size();
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    chk("busy_acc", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(output int dcyc);
    logic seen;
    seen = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic finish_msg(input int lat);
    int dcyc, nf;
    wait_done(dcyc);
    ndone_exp++;
    chk("busy_fin", 32'(busy), 32'd0);
    nf = fall_cyc.size() - base;
    chk("nchars", 32'(nf), 32'(nexp));
    if (nf > 0) begin
      chk("latency", 32'(fall_cyc[base] - acc), 32'(lat));
      for (int i = base + 1; i < fall_cyc.size(); i++)
        chk("char_gap", 32'(fall_cyc[i] - fall_cyc[i-1]),
            32'(NB * CPB + 1));
      chk("frame_end", 32'(dcyc - fall_cyc[fall_cyc.size()-1]),
          32'(NB * CPB));
    end
    chk("q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int dc;
    fork
      uart_mon();
      done_mon();
    join_none

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b1;

    send(8'd255, 1'b0);
    finish_msg(10);
    send(8'd0, 1'b0);
    finish_msg(10);
    send(8'd42, 1'b0);
    finish_msg(10);
    send(8'h99, 1'b1);
    finish_msg(2);

    send(8'd7, 1'b0);
    repeat (200) @(negedge clk);
    result = 8'd9;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("busy_ign", 32'(busy), 32'd1);
    finish_msg(10);
    send(8'd9, 1'b0);
    finish_msg(10);

    send(8'd3, 1'b0);
    finish_msg(10);

    send(8'd123, 1'b0);
    repeat (400) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    base = fall_cyc.size();
    dc = done_cnt;
    repeat (400) @(negedge clk);
    chk("abort_nofall", 32'(fall_cyc.size() - base), 32'd0);
    chk("abort_nodone", 32'(done_cnt), 32'(dc));
    chk("abort_idle_tx", 32'(tx), 32'd1);

    chk("done_total", 32'(done_cnt), 32'(ndone_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Downstream stage of the ALU datapath. Captures the 8-bit operation result and the divide-by-zero flag when a start strobe arrives.
- Converts the result to unsigned decimal ASCII using a sequential double-dabble converter.
- Sends the text back to the host over UART 8N1, so the host sees the answer as well as the 7-segment display.
- Sits beside the LED driver and takes the same mux output.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 9600: UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division, must be at least 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- result  in  8  unsigned ALU result.
- div0  in  1  divide-by-zero flag for the current result.
- start  in  1  single-cycle request to transmit result/div0.
- busy  out  1  high from acceptance until the last stop bit completes.
- done  out  1  one-cycle pulse after the final stop bit.
- tx  out  1  UART serial output, idles high.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst).
- Reset values: tx=1, busy=0, done=0, FSM=IDLE, all counters and registers 0.
- Reset asserted mid-frame aborts immediately; tx returns to 1 with no partial byte completion.
- Acceptance: start is sampled only in IDLE. At that edge, result and div0 are latched, and busy=1 from the next cycle.
- start while busy=1 is ignored; no queueing.
- States: IDLE -> CONV -> LOAD -> START_BIT -> DATA -> STOP -> (LOAD or FIN) -> IDLE.
- CONV: 8 iterations of shift-and-add-3, one per clock, giving hundreds/tens/ones BCD. It is skipped when div0=1.
- Message content:
  - div0=0: decimal digits with leading zeros suppressed (the ones digit is always sent), then CR (0x0D) and LF (0x0A). Examples: 0 -> "0\r\n", 7 -> "7\r\n", 42 -> "42\r\n", 255 -> "255\r\n".
  - div0=1: "ERR\r\n" (0x45 0x52 0x52 0x0D 0x0A); result is ignored.
- Message length is 3 to 5 characters. A character index counter selects the next byte in LOAD (one cycle per character).
- Bit timing: every bit (start=0, 8 data bits LSB first, stop=1) lasts exactly CLKS_PER_BIT clocks, counted by a baud counter that reloads at each bit boundary.
- There is no idle gap between characters beyond the single LOAD cycle.
- FIN: done=1 for one cycle and busy=0 in the same cycle. The FSM is in IDLE on the following cycle, so back-to-back start is accepted one cycle after done.
- Latency: first start-bit falling edge is 10 clocks after the accepting edge (1 latch + 8 CONV + 1 LOAD). For div0 it is 2 clocks.

Optional Feature:
- Macro RESULT_TX_PARITY_EN.
- Defined: an even parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bit, one bit-time long. The frame becomes 8E1.
- Undefined: 8N1 exactly as above, and no parity logic is synthesised.

Decomposition:
- Shared package alu_uart_pkg:
  - ASCII constants: ZERO=0x30, CR, LF, 'E', 'R'.
  - FSM state enum.
  - CLKS_PER_BIT function, also reused by UART_RX.
- Sub-module bin2bcd_8bit:
  - Sequential double-dabble with start/done handshake, 8-bit in, 12-bit BCD out, fixed 8-cycle latency.
  - The top FSM waits on its done signal.

Test Plan (CLK_FREQ=1600, BAUD=100, so 16 clocks/bit):
1. Reset: assert rst=0 mid-frame of a transmission of 123 -> tx=1 and busy=0 immediately. After release, tx stays high and done never pulses.
2. Decimal encoding: start with result=255, div0=0 -> bytes 0x32 0x35 0x35 0x0D 0x0A. Each frame is 160 clocks, and done pulses once after the 5th stop bit.
3. Leading-zero suppression: result=0 -> 0x30 0x0D 0x0A. result=42 -> 0x34 0x32 0x0D 0x0A.
4. Divide-by-zero: div0=1, result=0x99 -> 0x45 0x52 0x52 0x0D 0x0A. First start bit appears 2 clocks after acceptance.
5. Busy handling: pulse start again during a transmission of 7 with result=9 -> ignored, only "7\r\n" sent. Then start on the cycle after done with result=9 -> "9\r\n" sent.
6. RESULT_TX_PARITY_EN defined: result=3 -> byte 0x33 carries parity bit 0, and LF (0x0A) carries parity bit 0. CR (0x0D) carries parity bit 1. Each frame is 176 clocks.
